// File: rtl/marker_pkg.sv
// Shared types for the marker pipeline: colour codes, the run record carried
// from the run extractor to the marker locator, and the run FSM state.
//   COL_*        3-bit colour codes (bit0 R, bit1 G, bit2 B)
//   run_rec_t    {colour, x, y, len}; coordinate fields are wide enough for any
//                supported image size and are narrowed at the extractor outputs
//   run_state_t  run tracker state
package marker_pkg;

   localparam logic [2:0] COL_BLACK   = 3'b000;
   localparam logic [2:0] COL_RED     = 3'b001;
   localparam logic [2:0] COL_GREEN   = 3'b010;
   localparam logic [2:0] COL_YELLOW  = 3'b011;
   localparam logic [2:0] COL_BLUE    = 3'b100;
   localparam logic [2:0] COL_MAGENTA = 3'b101;
   localparam logic [2:0] COL_CYAN    = 3'b110;
   localparam logic [2:0] COL_WHITE   = 3'b111;

   // Image dimensions must stay below 2**REC_FIELD_W.
   localparam int unsigned REC_FIELD_W = 16;

   typedef struct packed {
      logic [2:0]             colour;
      logic [REC_FIELD_W-1:0] x;
      logic [REC_FIELD_W-1:0] y;
      logic [REC_FIELD_W-1:0] len;
   } run_rec_t;

   typedef enum logic {RUN_IDLE, RUN_ACTIVE} run_state_t;

endpackage

// File: rtl/run_fifo.sv
// Synchronous FIFO of run records. No fall-through: a record pushed into an
// empty FIFO appears on rec_out after the push edge. A push while full is
// accepted only if a pop happens in the same cycle.
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   push_in, rec_in    write request and record
//   pop_in             read request (ignored when empty)
//   rec_out            head record (undefined when empty)
//   full_out           DEPTH entries held
//   empty_out          no entries held
module run_fifo
   import marker_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic     clk_in,
   input  logic     rst_n_in,
   input  logic     push_in,
   input  run_rec_t rec_in,
   input  logic     pop_in,
   output run_rec_t rec_out,
   output logic     full_out,
   output logic     empty_out
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   run_rec_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign empty_out = (count_q == '0);
   assign full_out  = (count_q == FULL_CNT);
   assign do_pop    = pop_in & ~empty_out;
   assign do_push   = push_in & (~full_out | do_pop);
   assign rec_out   = mem_q[rd_ptr_q];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: consumers only look at it while non-empty.
   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q] <= rec_in;
   end

endmodule

// File: rtl/colour_run_extract.sv
// Finds horizontal runs of identical tracked colour codes in a thresholded
// pixel stream and queues one record per run of at least MIN_RUN pixels.
//   clk_in, rst_n_in        pixel clock, asynchronous active-low reset
//   pix_valid_in            qualifies colour_in/sof_in/eol_in
//   colour_in               pixel colour code
//   sof_in, eol_in          first pixel of frame / last pixel of line
//   run_valid_out/ready_in  record handshake towards the marker locator
//   run_colour/x/y/len_out  head record (0 while no record is available)
//   overflow_out            sticky: a record was dropped because the FIFO was full
module colour_run_extract
   import marker_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned MIN_RUN    = 4,
   parameter logic [7:0]  TRACK_MASK = 8'h06,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                              clk_in,
   input  logic                              rst_n_in,
   input  logic                              pix_valid_in,
   input  logic [2:0]                        colour_in,
   input  logic                              sof_in,
   input  logic                              eol_in,
   output logic                              run_valid_out,
   input  logic                              run_ready_in,
   output logic [2:0]                        run_colour_out,
   output logic [$clog2(IMG_WIDTH)-1:0]      run_x_out,
   output logic [$clog2(IMG_HEIGHT)-1:0]     run_y_out,
   output logic [$clog2(IMG_WIDTH+1)-1:0]    run_len_out,
   output logic                              overflow_out
);

   localparam int unsigned XW = $clog2(IMG_WIDTH);
   localparam int unsigned YW = $clog2(IMG_HEIGHT);
   localparam int unsigned LW = $clog2(IMG_WIDTH + 1);
   localparam logic [XW-1:0] X_MAX   = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX   = YW'(IMG_HEIGHT - 1);
   localparam logic [LW-1:0] MIN_LEN = LW'(MIN_RUN);

   run_state_t    state_q, state_d, st;
   logic [2:0]    cur_col_q, cur_col_d;
   logic [XW-1:0] x0_q, x0_d, x_q, x_d, px_x;
   logic [YW-1:0] y_q, y_d, px_y;
   logic [LW-1:0] len_q, len_d;
   logic          sat_q, sat_d;
   logic          tracked, close;
   logic [2:0]    close_col;
   logic [XW-1:0] close_x;
   logic [LW-1:0] close_len;
   run_rec_t      close_rec, push_rec_q, head;
   logic          push_q, overflow_q;
   logic          fifo_full, fifo_empty, pop, drop;

   always_comb begin
      state_d   = state_q;
      cur_col_d = cur_col_q;
      x0_d      = x0_q;
      len_d     = len_q;
      x_d       = x_q;
      y_d       = y_q;
      sat_d     = sat_q;
      close     = 1'b0;
      close_col = cur_col_q;
      close_x   = x0_q;
      close_len = len_q;
      // sof relocates the pixel to (0,0) and discards any open run.
      px_x      = sof_in ? '0 : x_q;
      px_y      = sof_in ? '0 : y_q;
      st        = sof_in ? RUN_IDLE : state_q;
      tracked   = TRACK_MASK[colour_in];

      if (pix_valid_in) begin
         if (sat_q && !sof_in) begin
            // Past the right edge: pixels are ignored, eol still ends the line.
            if (eol_in) begin
               close   = (state_q == RUN_ACTIVE);
               state_d = RUN_IDLE;
            end
         end else begin
            unique case (st)
               RUN_IDLE: begin
                  state_d = RUN_IDLE;
                  if (tracked && eol_in) begin
                     close     = 1'b1;
                     close_col = colour_in;
                     close_x   = px_x;
                     close_len = LW'(1);
                  end else if (tracked) begin
                     state_d   = RUN_ACTIVE;
                     cur_col_d = colour_in;
                     x0_d      = px_x;
                     len_d     = LW'(1);
                  end
               end
               RUN_ACTIVE: begin
                  if (colour_in == cur_col_q) begin
                     close_len = len_q + LW'(1);
                     len_d     = len_q + LW'(1);
                     if (eol_in) begin
                        close   = 1'b1;
                        state_d = RUN_IDLE;
                     end
                  end else begin
                     close = 1'b1;
                     // A different colour on eol would be a one-pixel run that
                     // closes together with the current one; it is not opened.
                     if (tracked && !eol_in) begin
                        state_d   = RUN_ACTIVE;
                        cur_col_d = colour_in;
                        x0_d      = px_x;
                        len_d     = LW'(1);
                     end else begin
                        state_d = RUN_IDLE;
                     end
                  end
               end
               default: state_d = RUN_IDLE;
            endcase
         end

         if (eol_in) begin
            x_d   = '0;
            y_d   = (px_y == Y_MAX) ? px_y : px_y + 1'b1;
            sat_d = 1'b0;
         end else if (px_x == X_MAX) begin
            x_d   = px_x;
            y_d   = px_y;
            sat_d = 1'b1;
         end else begin
            x_d   = px_x + 1'b1;
            y_d   = px_y;
            sat_d = 1'b0;
         end
      end

      close_rec.colour = close_col;
      close_rec.x      = REC_FIELD_W'(close_x);
      close_rec.y      = REC_FIELD_W'(px_y);
      close_rec.len    = REC_FIELD_W'(close_len);
   end

   assign pop  = run_valid_out & run_ready_in;
   assign drop = push_q & fifo_full & ~pop;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= RUN_IDLE;
         cur_col_q  <= COL_BLACK;
         x0_q       <= '0;
         len_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         sat_q      <= 1'b0;
         push_q     <= 1'b0;
         push_rec_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_col_q  <= cur_col_d;
         x0_q       <= x0_d;
         len_q      <= len_d;
         x_q        <= x_d;
         y_q        <= y_d;
         sat_q      <= sat_d;
         push_q     <= close && (close_len >= MIN_LEN);
         if (close) push_rec_q <= close_rec;
         overflow_q <= overflow_q | drop;
      end
   end

   run_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_run_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .push_in   (push_q),
      .rec_in    (push_rec_q),
      .pop_in    (pop),
      .rec_out   (head),
      .full_out  (fifo_full),
      .empty_out (fifo_empty)
   );

   assign run_valid_out  = ~fifo_empty;
   assign run_colour_out = run_valid_out ? head.colour : '0;
   assign run_x_out      = run_valid_out ? head.x[XW-1:0] : '0;
   assign run_y_out      = run_valid_out ? head.y[YW-1:0] : '0;
   assign run_len_out    = run_valid_out ? head.len[LW-1:0] : '0;
   assign overflow_out   = overflow_q;

   logic unused_head;
   assign unused_head = ^{head.x[REC_FIELD_W-1:XW], head.y[REC_FIELD_W-1:YW],
                          head.len[REC_FIELD_W-1:LW]};

endmodule

// File: tb/tb_colour_run_extract.sv
module tb_colour_run_extract;
   import marker_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_valid;
   logic [2:0] colour;
   logic       sof, eol;
   logic       run_valid, run_ready;
   logic [2:0] run_colour;
   logic [3:0] run_x;
   logic [1:0] run_y;
   logic [4:0] run_len;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   colour_run_extract #(
      .IMG_WIDTH  (16),
      .IMG_HEIGHT (4),
      .MIN_RUN    (3),
      .TRACK_MASK (8'h06),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .pix_valid_in   (pix_valid),
      .colour_in      (colour),
      .sof_in         (sof),
      .eol_in         (eol),
      .run_valid_out  (run_valid),
      .run_ready_in   (run_ready),
      .run_colour_out (run_colour),
      .run_x_out      (run_x),
      .run_y_out      (run_y),
      .run_len_out    (run_len),
      .overflow_out   (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // One valid pixel per clock; returns 1 time unit after the sampling edge.
   task automatic pix(input logic [2:0] c, input logic s, input logic e);
      pix_valid = 1'b1;
      colour    = c;
      sof       = s;
      eol       = e;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      pix_valid = 1'b0;
      sof       = 1'b0;
      eol       = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic peek(input string tag, input logic [2:0] c, input int x, input int y,
                       input int len);
      chk({tag, "_valid"}, 32'(run_valid), 1);
      chk({tag, "_colour"}, 32'(run_colour), 32'(c));
      chk({tag, "_x"}, 32'(run_x), x);
      chk({tag, "_y"}, 32'(run_y), y);
      chk({tag, "_len"}, 32'(run_len), len);
   endtask

   task automatic expect_rec(input string tag, input logic [2:0] c, input int x, input int y,
                             input int len);
      pix_valid = 1'b0;
      peek(tag, c, x, y, len);
      run_ready = 1'b1;
      @(posedge clk);
      #1;
      run_ready = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(run_valid), 0);
      chk({tag, "_colour"}, 32'(run_colour), 0);
      chk({tag, "_x"}, 32'(run_x), 0);
      chk({tag, "_y"}, 32'(run_y), 0);
      chk({tag, "_len"}, 32'(run_len), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      pix_valid = 1'b0;
      colour    = COL_BLACK;
      sof       = 1'b0;
      eol       = 1'b0;
      run_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      idle(1);

      // Line 0: 2 black, 5 red, 9 black; red run closed by x=7.
      pix(COL_BLACK, 1'b1, 1'b0);
      pix(COL_BLACK, 1'b0, 1'b0);
      repeat (5) pix(COL_RED, 1'b0, 1'b0);
      pix(COL_BLACK, 1'b0, 1'b0);
      chk("l0_lat1", 32'(run_valid), 0);
      pix(COL_BLACK, 1'b0, 1'b0);
      chk("l0_lat2", 32'(run_valid), 1);
      repeat (6) pix(COL_BLACK, 1'b0, 1'b0);
      pix(COL_BLACK, 1'b0, 1'b1);
      expect_rec("l0_rec", COL_RED, 2, 0, 5);
      chk("l0_empty", 32'(run_valid), 0);

      // Line 1: 4 red then 4 green back-to-back.
      repeat (4) pix(COL_RED, 1'b0, 1'b0);
      repeat (4) pix(COL_GREEN, 1'b0, 1'b0);
      repeat (7) pix(COL_BLACK, 1'b0, 1'b0);
      pix(COL_BLACK, 1'b0, 1'b1);
      expect_rec("l1_red", COL_RED, 0, 1, 4);
      expect_rec("l1_green", COL_GREEN, 4, 1, 4);
      chk("l1_empty", 32'(run_valid), 0);

      // Line 2: short green run broken by blue, then red ending on eol.
      repeat (2) pix(COL_GREEN, 1'b0, 1'b0);
      pix(COL_BLUE, 1'b0, 1'b0);
      repeat (9) pix(COL_BLACK, 1'b0, 1'b0);
      repeat (3) pix(COL_RED, 1'b0, 1'b0);
      pix(COL_RED, 1'b0, 1'b1);
      chk("l2_lat1", 32'(run_valid), 0);
      idle(1);
      expect_rec("l2_eol", COL_RED, 12, 2, 4);
      chk("l2_empty", 32'(run_valid), 0);

      // Line 3: five 3-pixel runs with the consumer stalled.
      for (int i = 0; i < 5; i++) begin
         repeat (3) pix((i % 2 == 0) ? COL_RED : COL_GREEN, 1'b0, 1'b0);
      end
      chk("l3_full_valid", 32'(run_valid), 1);
      chk("l3_no_ovf_yet", 32'(overflow), 0);
      pix(COL_BLACK, 1'b0, 1'b1);
      idle(2);
      chk("l3_ovf", 32'(overflow), 1);
      peek("l3_head", COL_RED, 0, 3, 3);

      // Line 4 (y saturated): push lands on a full FIFO together with a pop.
      repeat (4) pix(COL_RED, 1'b0, 1'b0);
      pix(COL_BLACK, 1'b0, 1'b0);
      run_ready = 1'b1;
      pix(COL_BLACK, 1'b0, 1'b0);
      run_ready = 1'b0;
      repeat (9) pix(COL_BLACK, 1'b0, 1'b0);
      pix(COL_BLACK, 1'b0, 1'b1);
      idle(1);
      expect_rec("q1", COL_GREEN, 3, 3, 3);
      expect_rec("q2", COL_RED, 6, 3, 3);
      expect_rec("q3", COL_GREEN, 9, 3, 3);
      expect_rec("q4", COL_RED, 0, 3, 4);
      chk("q_empty", 32'(run_valid), 0);

      // sof in the middle of a red run discards it; new frame restarts at (0,0).
      pix(COL_BLACK, 1'b1, 1'b0);
      repeat (4) pix(COL_BLACK, 1'b0, 1'b0);
      repeat (5) pix(COL_RED, 1'b0, 1'b0);
      pix(COL_BLACK, 1'b1, 1'b0);
      repeat (3) pix(COL_RED, 1'b0, 1'b0);
      pix(COL_BLACK, 1'b0, 1'b0);
      repeat (10) pix(COL_BLACK, 1'b0, 1'b0);
      pix(COL_BLACK, 1'b0, 1'b1);
      idle(2);
      peek("sof_rec", COL_RED, 1, 0, 3);
      chk("pre_rst_ovf", 32'(overflow), 1);

      // Reset in the middle of an open red run, with a record queued.
      repeat (4) pix(COL_RED, 1'b0, 1'b0);
      pix_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pix(COL_BLACK, 1'b0, 1'b0);
      repeat (3) pix(COL_GREEN, 1'b0, 1'b0);
      pix(COL_BLACK, 1'b0, 1'b0);
      idle(2);
      expect_rec("post_rst", COL_GREEN, 1, 0, 3);
      chk("post_rst_empty", 32'(run_valid), 0);
      chk("post_rst_ovf", 32'(overflow), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
